// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_if: requester/bank bundle for jk_bank_arbiter.
//   master modport: the requester side (drives valid/idx/jk, observes grants,
//                   done pulses, bank contents and busy).
//   slave modport : the bank/arbiter side.
// Signals:
//   a_valid/a_idx/a_jk -> a_ready/a_done   requester A command channel
//   b_valid/b_idx/b_jk -> b_ready/b_done   requester B command channel
//   q          bank contents, one bit per JK cell
//   busy       a captured command is pending
//   state_dbg  raw FSM state (0 = IDLE, 1 = APPLY)
// Handshake: a command transfers on a cycle where valid && ready are both
// high at the rising clock edge. A requester holds valid, idx and jk stable
// until it sees ready; ready never depends on a requester's own idx/jk.
interface jk_bank_if #(
    parameter int N_CELLS = 8,
    parameter int IDX_W   = 3
);
    logic               a_valid;
    logic [IDX_W-1:0]   a_idx;
    logic [1:0]         a_jk;
    logic               a_ready;
    logic               a_done;
    logic               b_valid;
    logic [IDX_W-1:0]   b_idx;
    logic [1:0]         b_jk;
    logic               b_ready;
    logic               b_done;
    logic [N_CELLS-1:0] q;
    logic               busy;
    logic               state_dbg;

    modport master (
        output a_valid, a_idx, a_jk, b_valid, b_idx, b_jk,
        input  a_ready, a_done, b_ready, b_done, q, busy, state_dbg
    );

    modport slave (
        input  a_valid, a_idx, a_jk, b_valid, b_idx, b_jk,
        output a_ready, a_done, b_ready, b_done, q, busy, state_dbg
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: bank of N_CELLS JK storage cells shared by two requesters
// (A and B) through a two-state round-robin arbiter.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   clr  synchronous clear of the whole bank (wins over everything else)
//   bus  jk_bank_if slave modport: per-requester valid/idx/jk/ready/done,
//        bank contents q, busy and state_dbg
// Timing: accept in cycle N (IDLE), apply at the end of N+1 (APPLY), result
// and the matching done pulse visible in N+2, which is IDLE again and may
// accept the next command.
module jk_bank_arbiter #(
    parameter int N_CELLS = 8,
    parameter int IDX_W   = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    jk_bank_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         jk_q, jk_d;
    logic               req_b_q, req_b_d;       // latched requester: 1 = B
    logic               favour_a_q, favour_a_d; // tie winner: 1 = A
    logic [N_CELLS-1:0] q_q, q_d;
    logic               a_done_q, a_done_d;
    logic               b_done_q, b_done_d;
    logic               grant_a, grant_b;

    // Grants are only offered in IDLE, out of reset and without a clear.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst && !clr && (state_q == IDLE)) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = favour_a_q;
                grant_b = !favour_a_q;
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        jk_d       = jk_q;
        req_b_d    = req_b_q;
        favour_a_d = favour_a_q;
        q_d        = q_q;
        a_done_d   = 1'b0;
        b_done_d   = 1'b0;
        if (clr) begin
            // Pending command is discarded; the tie pointer is kept.
            state_d = IDLE;
            q_d     = '0;
        end else if (state_q == IDLE) begin
            if (grant_a || grant_b) begin
                state_d    = APPLY;
                idx_d      = grant_b ? bus.b_idx : bus.a_idx;
                jk_d       = grant_b ? bus.b_jk  : bus.a_jk;
                req_b_d    = grant_b;
                favour_a_d = grant_b; // the requester just served loses the next tie
            end
        end else begin
            for (int i = 0; i < N_CELLS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    case (jk_q)
                        2'b01:   q_d[i] = 1'b0;
                        2'b10:   q_d[i] = 1'b1;
                        2'b11:   q_d[i] = ~q_q[i];
                        default: q_d[i] = q_q[i];
                    endcase
                end
            end
            a_done_d = !req_b_q;
            b_done_d = req_b_q;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            jk_q       <= 2'b00;
            req_b_q    <= 1'b0;
            favour_a_q <= 1'b1;
            q_q        <= '0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            jk_q       <= jk_d;
            req_b_q    <= req_b_d;
            favour_a_q <= favour_a_d;
            q_q        <= q_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.a_done    = a_done_q;
    assign bus.b_done    = b_done_q;
    assign bus.q         = q_q;
    assign bus.busy      = (state_q == APPLY);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed bench for jk_bank_arbiter. Each issued command
// pushes {requester, expected q} into exp_q; a monitor pops one entry per done
// pulse and compares it with {b_done, q}.
module tb_jk_bank_arbiter;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int W  = 1 + N;

    logic clk;
    logic rst;
    logic clr;
    logic [W-1:0] exp_q[$];
    logic [N-1:0] acc;
    int n_vec = 0;
    int n_err = 0;

    jk_bank_if #(.N_CELLS(N), .IDX_W(IW)) bus ();

    jk_bank_arbiter #(.N_CELLS(N), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: run did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive_a(input logic v, input logic [IW-1:0] idx, input logic [1:0] jk);
        bus.a_valid = v;
        bus.a_idx   = idx;
        bus.a_jk    = jk;
    endtask

    task automatic drive_b(input logic v, input logic [IW-1:0] idx, input logic [1:0] jk);
        bus.b_valid = v;
        bus.b_idx   = idx;
        bus.b_jk    = jk;
    endtask

    // Single requester command with full latency checks.
    task automatic issue(input logic who, input logic [IW-1:0] idx, input logic [1:0] jk,
                         input logic [N-1:0] exp_qv);
        int n;
        exp_q.push_back({who, exp_qv});
        @(posedge clk); #1;
        if (who) drive_b(1'b1, idx, jk); else drive_a(1'b1, idx, jk);
        n = 0;
        @(negedge clk);
        while (((who ? bus.b_ready : bus.a_ready) !== 1'b1) && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("grant", {bus.a_ready, bus.b_ready}, who ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        if (who) drive_b(1'b0, '0, 2'b00); else drive_a(1'b0, '0, 2'b00);
        @(negedge clk);
        check("apply_busy", {bus.busy, bus.a_ready, bus.b_ready}, 3'b100);
        @(negedge clk);
        check("done_timing", {bus.busy, bus.a_done, bus.b_done}, who ? 3'b001 : 3'b010);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst === 1'b1) begin
            check("done_exclusive", {31'd0, bus.a_done & bus.b_done}, 32'd0);
            if (bus.a_done === 1'b1 || bus.b_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {bus.a_done, bus.b_done}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_done", {bus.b_done, bus.q}, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        clr = 1'b0;
        drive_a(1'b1, 3'd3, 2'b10);
        drive_b(1'b1, 3'd0, 2'b10);
        #1 rst = 1'b0;
        #2;
        check("reset_state", {bus.busy, bus.a_ready, bus.b_ready, bus.a_done, bus.b_done, bus.q}, 0);
        @(posedge clk);
        @(negedge clk);
        check("reset_no_grant", {bus.busy, bus.a_ready, bus.b_ready, bus.q}, 0);
        drive_a(1'b0, '0, 2'b00);
        drive_b(1'b0, '0, 2'b00);
        #2 rst = 1'b1;

        // A sets cell 3
        issue(1'b0, 3'd3, 2'b10, 8'h08);
        // B hold: q unchanged, B becomes last served
        issue(1'b1, 3'd0, 2'b00, 8'h08);

        // Tie: A toggles 3, B sets 0
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h01});
        drive_a(1'b1, 3'd3, 2'b11);
        drive_b(1'b1, 3'd0, 2'b10);
        @(negedge clk);
        check("tie_grant_a", {bus.a_ready, bus.b_ready}, 2'b10);
        @(posedge clk); #1;
        drive_a(1'b0, '0, 2'b00);
        @(negedge clk);
        check("tie_apply", {bus.busy, bus.a_ready, bus.b_ready}, 3'b100);
        @(negedge clk);
        check("tie_a_done_b_ready", {bus.a_done, bus.b_ready, bus.q}, {2'b11, 8'h00});
        @(posedge clk); #1;
        drive_b(1'b0, '0, 2'b00);
        @(negedge clk);
        check("tie_b_apply", {bus.busy, bus.b_done}, 2'b10);
        @(negedge clk);
        check("tie_b_done", {bus.a_done, bus.b_done, bus.q}, {2'b01, 8'h01});

        // Alternating hold grants
        @(posedge clk); #1;
        for (int g = 0; g < 8; g++) exp_q.push_back({g[0], 8'h01});
        drive_a(1'b1, 3'd2, 2'b00);
        drive_b(1'b1, 3'd6, 2'b00);
        for (int g = 0; g < 8; g++) begin
            n = 0;
            @(negedge clk);
            while (bus.a_ready !== 1'b1 && bus.b_ready !== 1'b1 && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("rr_grant", {bus.a_ready, bus.b_ready}, g[0] ? 2'b01 : 2'b10);
            @(posedge clk); #1;
            if (g == 7) begin
                drive_a(1'b0, '0, 2'b00);
                drive_b(1'b0, '0, 2'b00);
            end
        end
        @(negedge clk);
        @(negedge clk);

        // Fill the bank
        acc = 8'h01;
        for (int i = 0; i < N; i++) begin
            acc[i] = 1'b1;
            issue(1'b0, i[IW-1:0], 2'b10, acc);
        end

        // Clear during APPLY drops B's command
        @(posedge clk); #1;
        drive_b(1'b1, 3'd5, 2'b01);
        @(negedge clk);
        check("clr_b_grant", {bus.a_ready, bus.b_ready}, 2'b01);
        @(posedge clk); #1;
        drive_b(1'b0, '0, 2'b00);
        clr = 1'b1;
        @(negedge clk);
        check("clr_in_apply", {bus.busy, bus.a_ready, bus.b_ready, bus.q}, {3'b100, 8'hFF});
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr_result", {bus.busy, bus.a_done, bus.b_done, bus.q}, {3'b000, 8'h00});
        @(negedge clk);
        check("clr_no_done", {bus.busy, bus.a_done, bus.b_done}, 3'b000);

        // Clear in IDLE masks grants
        @(posedge clk); #1;
        clr = 1'b1;
        drive_a(1'b1, 3'd1, 2'b10);
        @(negedge clk);
        check("clr_blocks_ready", {bus.a_ready, bus.b_ready}, 2'b00);
        @(posedge clk); #1;
        clr = 1'b0;
        drive_a(1'b0, '0, 2'b00);
        @(negedge clk);
        check("clr_idle_hold", {bus.busy, bus.q}, {1'b0, 8'h00});

        // Reset during APPLY
        issue(1'b0, 3'd0, 2'b10, 8'h01);
        @(posedge clk); #1;
        drive_a(1'b1, 3'd0, 2'b11);
        @(negedge clk);
        check("rst_a_grant", {bus.a_ready, bus.b_ready}, 2'b10);
        @(posedge clk); #1;
        drive_a(1'b0, '0, 2'b00);
        @(negedge clk);
        check("rst_pre_apply", {bus.busy, bus.q}, {1'b1, 8'h01});
        #2 rst = 1'b0;
        #1;
        check("async_reset", {bus.busy, bus.a_ready, bus.b_ready, bus.a_done, bus.b_done, bus.q}, 0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_no_done", {bus.busy, bus.a_done, bus.b_done, bus.q}, 0);

        // First tie after reset goes to A
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        drive_a(1'b1, 3'd4, 2'b00);
        drive_b(1'b1, 3'd2, 2'b00);
        @(negedge clk);
        check("post_rst_tie", {bus.a_ready, bus.b_ready}, 2'b10);
        @(posedge clk); #1;
        drive_a(1'b0, '0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_b_ready", {bus.a_done, bus.b_ready}, 2'b11);
        @(posedge clk); #1;
        drive_b(1'b0, '0, 2'b00);
        @(negedge clk);
        @(negedge clk);

        // Back-to-back toggles of cell 7
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'h00});
        drive_a(1'b1, 3'd7, 2'b11);
        @(negedge clk);
        check("b2b_grant1", {bus.a_ready, bus.q}, {1'b1, 8'h00});
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_apply1", {bus.busy, bus.a_ready}, 2'b10);
        @(negedge clk);
        check("b2b_done1_grant2", {bus.a_done, bus.a_ready, bus.q}, {2'b11, 8'h80});
        @(posedge clk); #1;
        drive_a(1'b0, '0, 2'b00);
        @(negedge clk);
        check("b2b_apply2", {bus.busy, bus.q}, {1'b1, 8'h80});
        @(negedge clk);
        check("b2b_done2", {bus.a_done, bus.q}, {1'b1, 8'h00});

        repeat (3) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
